// File: rtl/skidmem_pkg.sv
// Shared types and helpers for the skidmem_credit read-streaming RAM.
package skidmem_pkg;

    localparam int unsigned MAX_MEM_LAT = 4;
    localparam int unsigned MAX_AW      = 32;

    // One read-pipeline stage: valid flag plus the address it carries.
    typedef struct packed {
        logic              vld;
        logic [MAX_AW-1:0] addr;
    } rd_stage_t;

    // Bits needed to count 0..depth inclusive.
    function automatic int unsigned credit_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/skidmem_obuf.sv
// Output FIFO for skidmem_credit: ring buffer with push/pop/clr; the head
// word stays stable until popped. Overflow is prevented by the caller's credits.
module skidmem_obuf
    import skidmem_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_vld
);

    localparam int unsigned   PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CNT_W = credit_w(DEPTH);
    localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);

    logic [WIDTH-1:0] slot_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign do_push   = push & ~clr;
    assign do_pop    = pop & head_vld & ~clr;
    assign head_vld  = (cnt_q != '0);
    assign head_data = slot_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            slot_q[wr_ptr_q] <= push_data;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(do_push && cnt_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/skidmem_credit.sv
// Simple dual-port RAM with a free-running MEM_LAT read pipeline feeding a
// credit-managed output FIFO. Define SKIDMEM_CREDIT_WR_FWD_EN for write-first reads.
module skidmem_credit
    import skidmem_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned MEM_LAT   = 2,
    parameter string       RAM_STYLE = "auto",
    localparam int unsigned AW         = $clog2(DEPTH),
    localparam int unsigned OBUF_DEPTH = MEM_LAT + 2,
    localparam int unsigned CW         = credit_w(OBUF_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    input  logic             rd_req_vld,
    output logic             rd_req_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             rd_dat_vld,
    input  logic             rd_dat_rdy,
    output logic [CW-1:0]    occupancy
);

    localparam logic [CW-1:0] CREDIT_MAX = CW'(OBUF_DEPTH);

    if (MEM_LAT < 1 || MEM_LAT > MAX_MEM_LAT) begin : g_bad_lat
        $error("skidmem_credit: MEM_LAT must be 1..%0d", MAX_MEM_LAT);
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("skidmem_credit: DEPTH must be at least 2");
    end
    if (RAM_STYLE == "") begin : g_bad_style
        $error("skidmem_credit: RAM_STYLE must not be empty");
    end

    (* ram_style = RAM_STYLE *) logic [WIDTH-1:0] mem_q [DEPTH];

    logic [WIDTH-1:0]   pipe_q [MEM_LAT];
    logic [WIDTH-1:0]   stage0;
    logic [WIDTH-1:0]   obuf_in;
    logic [MEM_LAT-1:0] vld_q, vld_d;
    logic [CW-1:0]      credit_q, credit_d;
    logic               rdy_q, rdy_d;
    logic               fire, pop, push;
    rd_stage_t          acc;
    logic               unused_addr_hi;

    assign fire = rd_req_vld & rdy_q;
    assign pop  = rd_dat_vld & rd_dat_rdy;
    assign push = vld_q[MEM_LAT-1] & ~clr;

    always_comb begin
        acc      = '0;
        acc.vld  = fire & ~clr;
        acc.addr = MAX_AW'(rd_addr);
    end

    assign unused_addr_hi = ^acc.addr[MAX_AW-1:AW];

    // Storage and data pipeline carry no enable so the output registers fold into the RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        pipe_q[0] <= mem_q[acc.addr[AW-1:0]];
        for (int unsigned k = 1; k < MEM_LAT; k++) begin
            pipe_q[k] <= (k == 1) ? stage0 : pipe_q[k-1];
        end
    end

`ifdef SKIDMEM_CREDIT_WR_FWD_EN
    // Same-cycle write hit at acceptance overrides the read-first RAM word one stage later.
    logic             fwd_hit_q;
    logic [WIDTH-1:0] fwd_dat_q;

    always_ff @(posedge clk) begin
        fwd_hit_q <= wr_en & (acc.addr == MAX_AW'(wr_addr));
        fwd_dat_q <= wr_data;
    end

    assign stage0 = fwd_hit_q ? fwd_dat_q : pipe_q[0];
`else
    assign stage0 = pipe_q[0];
`endif

    if (MEM_LAT == 1) begin : g_lat1
        assign obuf_in = stage0;
    end else begin : g_latn
        assign obuf_in = pipe_q[MEM_LAT-1];
    end

    always_comb begin
        vld_d = '0;
        if (!clr) begin
            vld_d[0] = acc.vld;
            for (int unsigned k = 1; k < MEM_LAT; k++) begin
                vld_d[k] = vld_q[k-1];
            end
        end
    end

    always_comb begin
        credit_d = credit_q;
        if (clr) begin
            credit_d = CREDIT_MAX;
        end else begin
            credit_d = credit_q - CW'(fire) + CW'(pop);
        end
        rdy_d = (credit_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            credit_q <= CREDIT_MAX;
            rdy_q    <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            credit_q <= credit_d;
            rdy_q    <= rdy_d;
        end
    end

    skidmem_obuf #(
        .WIDTH (WIDTH),
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .push      (push),
        .push_data (obuf_in),
        .pop       (pop),
        .head_data (rd_dat),
        .head_vld  (rd_dat_vld)
    );

    assign rd_req_rdy = rdy_q;
    assign occupancy  = CREDIT_MAX - credit_q;

endmodule

// File: tb/tb_skidmem_credit.sv
// Testbench for skidmem_credit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_skidmem_credit;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned DEPTH   = 32;
    localparam int unsigned MEM_LAT = 2;
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned OBUF    = MEM_LAT + 2;
    localparam int unsigned CW      = $clog2(OBUF + 1);
`ifdef SKIDMEM_CREDIT_WR_FWD_EN
    localparam logic [WIDTH-1:0] RDW_EXP = 16'h000B;
`else
    localparam logic [WIDTH-1:0] RDW_EXP = 16'h000A;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [AW-1:0]    rd_addr = '0;
    logic             rd_req_vld = 1'b0;
    logic             rd_dat_rdy = 1'b0;
    logic             rd_req_rdy;
    logic [WIDTH-1:0] rd_dat;
    logic             rd_dat_vld;
    logic [CW-1:0]    occupancy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    skidmem_credit #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .MEM_LAT   (MEM_LAT),
        .RAM_STYLE ("block")
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_req_vld (rd_req_vld),
        .rd_req_rdy (rd_req_rdy),
        .rd_dat     (rd_dat),
        .rd_dat_vld (rd_dat_vld),
        .rd_dat_rdy (rd_dat_rdy),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted reads wait MEM_LAT cycles in pend_q, then sit in out_q.
    typedef struct {
        int               due;
        logic [WIDTH-1:0] d;
    } pend_t;

    pend_t            pend_q[$];
    logic [WIDTH-1:0] out_q[$];
    logic [WIDTH-1:0] mmem [DEPTH];
    logic             m_rdy = 1'b0;
    int               mcyc = 0;

    always @(posedge clk or negedge rst_n) begin : model
        logic [WIDTH-1:0] rv;
        pend_t            p;
        logic             fired;
        if (!rst_n) begin
            pend_q.delete();
            out_q.delete();
            m_rdy = 1'b0;
        end else begin
            fired = rd_req_vld && m_rdy;
            rv = mmem[rd_addr];
`ifdef SKIDMEM_CREDIT_WR_FWD_EN
            if (wr_en && wr_addr == rd_addr) rv = wr_data;
`endif
            if (wr_en) mmem[wr_addr] = wr_data;
            if (clr) begin
                pend_q.delete();
                out_q.delete();
            end else begin
                if (rd_dat_rdy && out_q.size() > 0) void'(out_q.pop_front());
                while (pend_q.size() > 0 && pend_q[0].due <= mcyc) begin
                    p = pend_q.pop_front();
                    out_q.push_back(p.d);
                end
                if (fired) begin
                    p.due = mcyc + MEM_LAT;
                    p.d   = rv;
                    pend_q.push_back(p);
                end
            end
            m_rdy = (pend_q.size() + out_q.size()) < OBUF;
            mcyc++;
        end
    end

    always @(negedge clk) begin
        check("rd_req_rdy", 32'(rd_req_rdy), 32'(m_rdy));
        check("rd_dat_vld", 32'(rd_dat_vld), 32'(out_q.size() > 0));
        check("occupancy", 32'(occupancy), 32'(pend_q.size() + out_q.size()));
        if (rd_dat_vld && out_q.size() > 0) check("rd_dat", 32'(rd_dat), 32'(out_q[0]));
    end

    // Logs of accepted requests and popped words for the directed checks.
    int               fire_c[$];
    logic [WIDTH-1:0] got_d[$];
    int               got_c[$];

    always @(negedge clk) begin
        if (rst_n && rd_req_vld && rd_req_rdy && !clr) fire_c.push_back(cyc);
        if (rst_n && rd_dat_vld && rd_dat_rdy && !clr) begin
            got_d.push_back(rd_dat);
            got_c.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        fire_c.delete();
        got_d.delete();
        got_c.delete();
    endtask

    task automatic issue(input int unsigned start, input int unsigned n);
        int unsigned a, done, guard;
        a = start; done = 0; guard = 0;
        while (done < n && guard < 200) begin
            rd_req_vld = 1'b1;
            rd_addr    = AW'(a);
            @(negedge clk);
            if (rd_req_rdy) begin
                a++;
                done++;
            end
            step();
            guard++;
        end
        rd_req_vld = 1'b0;
        check("issue_done", 32'(done), 32'(n));
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((rd_dat_vld || occupancy != '0) && g < 100) begin
            step();
            g++;
        end
        check("drain_empty", 32'(occupancy), 32'd0);
    endtask

    int nf = 0;
    int max_occ = 0;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdy", 32'(rd_req_rdy), 32'd0);
        check("reset_vld", 32'(rd_dat_vld), 32'd0);
        check("reset_occ", 32'(occupancy), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step();
        check("rdy_after_reset", 32'(rd_req_rdy), 32'd1);

        for (int i = 0; i < int'(DEPTH); i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = WIDTH'(i);
            step();
        end
        wr_en = 1'b0;

        // Streaming: 16 back-to-back reads, one word per cycle, 3-cycle first latency.
        clear_logs();
        rd_dat_rdy = 1'b1;
        issue(0, 16);
        drain();
        check("stream_count", 32'(got_d.size()), 32'd16);
        for (int k = 0; k < got_d.size() && fire_c.size() > 0; k++) begin
            check("stream_data", 32'(got_d[k]), 32'(k));
            check("stream_cycle", 32'(got_c[k]), 32'(fire_c[0] + 3 + k));
        end

        // Full backpressure: exactly OBUF fires, then stall.
        clear_logs();
        rd_dat_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rd_addr = AW'(fire_c.size());
            rd_req_vld = 1'b1;
            step();
        end
        rd_req_vld = 1'b0;
        check("bp_fires", 32'(fire_c.size()), 32'd4);
        check("bp_rdy", 32'(rd_req_rdy), 32'd0);
        check("bp_occ", 32'(occupancy), 32'd4);
        rd_dat_rdy = 1'b1;
        drain();
        check("bp_count", 32'(got_d.size()), 32'd4);
        for (int k = 0; k < got_d.size(); k++) check("bp_data", 32'(got_d[k]), 32'(k));

        // Read-during-write on address 5.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 16'h000A;
        step();
        clear_logs();
        wr_data = 16'h000B; rd_req_vld = 1'b1; rd_addr = 5'd5;
        step();
        wr_en = 1'b0; rd_req_vld = 1'b0;
        drain();
        check("rdw_count", 32'(got_d.size()), 32'd1);
        if (got_d.size() > 0) check("rdw_data", 32'(got_d[0]), 32'(RDW_EXP));
        clear_logs();
        issue(5, 1);
        drain();
        if (got_d.size() > 0) check("rdw_after", 32'(got_d[0]), 32'h000B);

        // Flush with two buffered and two in flight.
        clear_logs();
        rd_dat_rdy = 1'b0;
        issue(8, 4);
        check("pre_flush_occ", 32'(occupancy), 32'd4);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("flush_vld", 32'(rd_dat_vld), 32'd0);
        check("flush_occ", 32'(occupancy), 32'd0);
        check("flush_rdy", 32'(rd_req_rdy), 32'd1);
        rd_dat_rdy = 1'b1;
        repeat (6) step();
        check("flush_no_ghost", 32'(got_d.size()), 32'd0);
        issue(7, 1);
        drain();
        check("flush_read_count", 32'(got_d.size()), 32'd1);
        if (got_d.size() > 0) check("flush_read7", 32'(got_d[0]), 32'd7);

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 6; i++) begin
            rd_req_vld = 1'b1; rd_addr = AW'(10 + i);
            step();
        end
        check("pre_reset_vld", 32'(rd_dat_vld), 32'd1);
        #2;
        rst_n = 1'b0;
        rd_req_vld = 1'b0;
        #1;
        check("async_vld", 32'(rd_dat_vld), 32'd0);
        check("async_occ", 32'(occupancy), 32'd0);
        check("async_rdy", 32'(rd_req_rdy), 32'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        check("post_reset_rdy", 32'(rd_req_rdy), 32'd1);
        check("post_reset_occ", 32'(occupancy), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 40000 && nf < 10000; i++) begin
            rd_req_vld = ($urandom_range(0, 3) != 0);
            rd_addr    = AW'($urandom_range(0, DEPTH - 1));
            wr_en      = ($urandom_range(0, 1) == 1);
            wr_addr    = ($urandom_range(0, 3) == 0) ? rd_addr : AW'($urandom_range(0, DEPTH - 1));
            wr_data    = WIDTH'($urandom);
            rd_dat_rdy = ($urandom_range(0, 1) == 1);
            clr        = ($urandom_range(0, 499) == 0);
            @(negedge clk);
            if (rd_req_vld && rd_req_rdy && !clr) nf++;
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
            step();
        end
        rd_req_vld = 1'b0; wr_en = 1'b0; clr = 1'b0; rd_dat_rdy = 1'b1;
        drain();
        check("random_fires", 32'(nf >= 10000), 32'd1);
        check("random_occ_bound", 32'(max_occ <= int'(OBUF)), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
